instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage for the basic arithmetic processor. Owns the program counter and drives the address of the combinational program memory. Registers the returned 16-bit function code and 16-bit immediate into an instruction register. Hands each instruction to the execute/control stage over a valid/ready handshake, and accepts PC redirects for `branch` from that stage.

## Interface
- `ADDR_W`, 16: program counter / memory address width.
- `PROG_LEN`, 25: number of valid program words. Any PC ≥ `PROG_LEN` halts the fetch. Legal range 1..65535.
- `START_ADDR`, 0: PC value after reset.
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: begin fetching from `START_ADDR`; sampled only in IDLE.
- `mem_addr`, out, `ADDR_W`: program memory address. Combinationally equal to the PC register.
- `mem_fncode`, in, 16: program memory function code for `mem_addr`, valid in the same cycle.
- `mem_data`, in, 16: program memory immediate for `mem_addr`, valid in the same cycle.
- `ins_valid`, out, 1: the instruction register holds an instruction for execute.
- `ins_ready`, in, 1: execute accepts the instruction this cycle.
- `ins_fncode`, out, 16: registered function code.
- `ins_data`, out, 16: registered immediate.
- `ins_pc`, out, `ADDR_W`: address the current instruction was fetched from. Execute uses it for `ldpc`.
- `redirect`, in, 1: execute requests a PC change (`branch`). Honoured only on a transfer cycle.
- `redirect_pc`, in, `ADDR_W`: branch target.
- `halted`, out, 1: fetch has stopped (end of program).
- `instr_count`, out, 16: number of completed transfers. Saturates at 0xFFFF.

## Operation
- A transfer is a cycle with `ins_valid && ins_ready` at the rising edge.
- States: IDLE, FETCH, ISSUE, HALT.
- Reset values: state IDLE, PC = `START_ADDR`, `ins_valid` 0, `ins_fncode` 0, `ins_data` 0, `ins_pc` 0, `halted` 0, `instr_count` 0.
- IDLE:
  - `start` = 1 → FETCH.
  - Otherwise stay in IDLE.
- FETCH:
  - If PC ≥ `PROG_LEN` → HALT.
  - Otherwise capture `mem_fncode`/`mem_data` into `ins_fncode`/`ins_data`, set `ins_pc` = PC, PC = PC+1, `ins_valid` = 1, → ISSUE.
- ISSUE, no transfer: all `ins_*` outputs and the PC hold. `redirect` is ignored.
- ISSUE, transfer without `redirect`:
  - `instr_count` increments.
  - If PC < `PROG_LEN`: capture memory at PC exactly as in FETCH and stay in ISSUE, giving back-to-back issue with `ins_valid` held high.
  - Else `ins_valid` = 0 → HALT.
- ISSUE, transfer with `redirect`: `instr_count` increments, PC = `redirect_pc`, `ins_valid` = 0 → FETCH. FETCH then applies the `PROG_LEN` check to the target.
- HALT:
  - `halted` = 1 and `ins_valid` = 0.
  - `start` and `redirect` are ignored.
  - Only `rst` leaves HALT.
- `halted` is a registered output, set on entry to HALT.
- PC arithmetic is `ADDR_W`-bit modulo, but the `PROG_LEN` check always halts before wrap.
- The block does not decode opcodes. Opcode meaning is execute's concern; `branch` reaches this block only through `redirect`.

## Timing
- `mem_addr` changes in the same cycle the PC register changes. The memory is combinational, so the capture uses the same-cycle data.
- Start latency: `start` sampled at edge N → FETCH at edge N+1 captures → `ins_valid` = 1 after edge N+1.
- Throughput: one instruction per cycle while `ins_ready` = 1.
- Redirect penalty: exactly one bubble cycle with `ins_valid` = 0. The target is valid after the second edge following the redirect transfer.
- Backpressure: `ins_ready` = 0 freezes the stage with no loss or duplication of instructions.
- `rst` mid-operation: all outputs take their reset values immediately, without waiting for a clock edge. Any in-flight instruction is discarded. The next start fetches from `START_ADDR`.
- `instr_count` updates on the transfer edge.

## Test plan
- Reset, pulse `start`, hold `ins_ready` = 1 with the standard 25-word program:
  - `ins_pc` runs 0..24 on consecutive cycles.
  - pc0 gives fncode 0x0000 / data 0x0001; pc1 gives 0x1100.
  - After the pc24 transfer: `ins_valid` 0, `halted` 1, `instr_count` 25.
- Backpressure: `ins_ready` = 0 for 3 cycles while `ins_pc` = 5:
  - fncode 0x0200 / data 0x0002 held stable.
  - `mem_addr` stays 6; `instr_count` unchanged.
  - On release, the next instruction issued is pc 6 (0x4020).
- Redirect: `redirect` = 1, `redirect_pc` = 18 on the pc23 transfer:
  - One cycle with `ins_valid` 0.
  - Then `ins_pc` = 18 with fncode 0x1700; `instr_count` counts the pc23 instruction once.
- Redirect to out-of-range target: `redirect_pc` = 30 on a transfer → no further instruction issued, `halted` 1 within 2 cycles.
- Redirect while `ins_ready` = 0: `redirect` = 1, `redirect_pc` = 3 → ignored; issue continues sequentially.
- Async `rst` pulse between edges mid-run:
  - Outputs go to reset values before the next edge.
  - Restarting with `start` issues pc 0 with `instr_count` 0.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, addresses the combinational program
// memory, registers the returned instruction and issues it over valid/ready.
module instr_fetch #(
    parameter int ADDR_W     = 16,
    parameter int PROG_LEN   = 25,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_fncode,
    input  logic [15:0]       mem_data,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [15:0]       ins_fncode,
    output logic [15:0]       ins_data,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted,
    output logic [15:0]       instr_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
    localparam logic [31:0]       LEN_W32  = 32'(PROG_LEN);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              pc_in_range;
    logic              xfer;
    logic              load_ins;
    logic              valid_next;
    logic              halted_next;
    logic              count_inc;

    assign mem_addr    = pc;
    // Compare in 32 bits so the end-of-program check never sees a wrapped PC.
    assign pc_in_range = (32'(pc) < LEN_W32);
    assign xfer        = (state == ISSUE) && ins_valid && ins_ready;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
                else       state_next = IDLE;
            end
            FETCH: begin
                if (pc_in_range) state_next = ISSUE;
                else             state_next = HALT;
            end
            ISSUE: begin
                if (xfer && redirect)  state_next = FETCH;
                else if (xfer && !pc_in_range) state_next = HALT;
                else                   state_next = ISSUE;
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    // Datapath controls: what the registered outputs and PC take next.
    always_comb begin
        load_ins    = 1'b0;
        pc_next     = pc;
        valid_next  = ins_valid;
        halted_next = halted;
        count_inc   = 1'b0;
        case (state)
            IDLE: begin
                valid_next = 1'b0;
            end
            FETCH: begin
                if (pc_in_range) begin
                    load_ins   = 1'b1;
                    pc_next    = pc + ADDR_W'(1);
                    valid_next = 1'b1;
                end else begin
                    valid_next  = 1'b0;
                    halted_next = 1'b1;
                end
            end
            ISSUE: begin
                if (xfer) begin
                    count_inc = 1'b1;
                    if (redirect) begin
                        pc_next    = redirect_pc;
                        valid_next = 1'b0;
                    end else if (pc_in_range) begin
                        load_ins   = 1'b1;
                        pc_next    = pc + ADDR_W'(1);
                        valid_next = 1'b1;
                    end else begin
                        valid_next  = 1'b0;
                        halted_next = 1'b1;
                    end
                end else begin
                    pc_next = pc;
                end
            end
            HALT: begin
                valid_next  = 1'b0;
                halted_next = 1'b1;
            end
            default: begin
                valid_next = 1'b0;
            end
        endcase
    end

    // PC, instruction register, status and transfer counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= START_PC;
            ins_valid   <= 1'b0;
            ins_fncode  <= 16'h0000;
            ins_data    <= 16'h0000;
            ins_pc      <= '0;
            halted      <= 1'b0;
            instr_count <= 16'h0000;
        end else begin
            pc        <= pc_next;
            ins_valid <= valid_next;
            halted    <= halted_next;
            if (load_ins) begin
                ins_fncode <= mem_fncode;
                ins_data   <= mem_data;
                ins_pc     <= pc;
            end
            if (count_inc && (instr_count != 16'hFFFF)) begin
                instr_count <= instr_count + 16'h0001;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for the main run plus
// hand-written sequences for async reset, redirect and out-of-range redirect.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] mem_addr;
    logic [15:0] mem_fncode;
    logic [15:0] mem_data;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [15:0] ins_fncode;
    logic [15:0] ins_data;
    logic [15:0] ins_pc;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halted;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;

    instr_fetch #(.ADDR_W(16), .PROG_LEN(25), .START_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr),
        .mem_fncode(mem_fncode), .mem_data(mem_data), .ins_valid(ins_valid),
        .ins_ready(ins_ready), .ins_fncode(ins_fncode), .ins_data(ins_data),
        .ins_pc(ins_pc), .redirect(redirect), .redirect_pc(redirect_pc),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Standard program: fixed words where the plan names them, a simple
    // pattern elsewhere, poison beyond the end.
    function automatic logic [31:0] prog(input logic [15:0] a);
        case (a)
            16'd0:   prog = {16'h0000, 16'h0001};
            16'd1:   prog = {16'h1100, 16'h0005};
            16'd5:   prog = {16'h0200, 16'h0002};
            16'd6:   prog = {16'h4020, 16'h0000};
            16'd18:  prog = {16'h1700, 16'h0003};
            default: begin
                if (a < 16'd25) prog = {16'h3000 | a, a * 16'd7};
                else            prog = 32'hDEADBEEF;
            end
        endcase
    endfunction

    assign {mem_fncode, mem_data} = prog(mem_addr);

    typedef struct {
        logic        rdy;
        logic        rd;
        logic [15:0] rpc;
        logic        ev;
        logic [15:0] epc;
        logic [15:0] ecnt;
        logic [15:0] eaddr;
        logic        eh;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic rd, input logic [15:0] rpc,
                       input logic ev, input logic [15:0] epc, input logic [15:0] ecnt,
                       input logic [15:0] eaddr, input logic eh);
        vec_t v;
        v.rdy = rdy; v.rd = rd; v.rpc = rpc; v.ev = ev; v.epc = epc;
        v.ecnt = ecnt; v.eaddr = eaddr; v.eh = eh;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_issue(input string tag, input logic [15:0] epc, input logic [15:0] ecnt);
        logic [31:0] w;
        w = prog(epc);
        chk({tag, " valid"}, 32'(ins_valid), 32'd1);
        chk({tag, " pc"}, 32'(ins_pc), 32'(epc));
        chk({tag, " fncode"}, 32'(ins_fncode), 32'(w[31:16]));
        chk({tag, " data"}, 32'(ins_data), 32'(w[15:0]));
        chk({tag, " count"}, 32'(instr_count), 32'(ecnt));
    endtask

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        step();
        chk("start fetch-state valid", 32'(ins_valid), 32'd0);
        @(negedge clk);
        start = 1'b0;
        step();
        chk_issue("first issue", 16'd0, 16'd0);
        chk("first issue addr", 32'(mem_addr), 32'd1);
    endtask

    initial begin
        // Main-run vectors, starting with pc0 held in the instruction register.
        for (int k = 0; k < 5; k++)
            add(1'b1, 1'b0, 16'd0, 1'b1, 16'(k + 1), 16'(k + 1), 16'(k + 2), 1'b0);
        for (int k = 0; k < 3; k++)
            add(1'b0, 1'b0, 16'd0, 1'b1, 16'd5, 16'd5, 16'd6, 1'b0);
        add(1'b0, 1'b1, 16'd3, 1'b1, 16'd5, 16'd5, 16'd6, 1'b0);
        for (int k = 6; k <= 24; k++)
            add(1'b1, 1'b0, 16'd0, 1'b1, 16'(k), 16'(k), 16'(k + 1), 1'b0);
        add(1'b1, 1'b0, 16'd0, 1'b0, 16'd24, 16'd25, 16'd25, 1'b1);
        add(1'b1, 1'b1, 16'd3, 1'b0, 16'd24, 16'd25, 16'd25, 1'b1);

        #1;
        chk("reset valid", 32'(ins_valid), 32'd0);
        chk("reset halted", 32'(halted), 32'd0);
        chk("reset count", 32'(instr_count), 32'd0);
        chk("reset addr", 32'(mem_addr), 32'd0);
        chk("reset fncode", 32'(ins_fncode), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("idle stays idle", 32'(ins_valid), 32'd0);

        start_run();
        foreach (vecs[i]) begin
            @(negedge clk);
            ins_ready   = vecs[i].rdy;
            redirect    = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            step();
            chk($sformatf("vec%0d valid", i), 32'(ins_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d halted", i), 32'(halted), 32'(vecs[i].eh));
            chk($sformatf("vec%0d count", i), 32'(instr_count), 32'(vecs[i].ecnt));
            chk($sformatf("vec%0d addr", i), 32'(mem_addr), 32'(vecs[i].eaddr));
            if (vecs[i].ev) chk_issue($sformatf("vec%0d", i), vecs[i].epc, vecs[i].ecnt);
        end
        @(negedge clk);
        redirect = 1'b0;

        // Async reset out of HALT, then a fresh run interrupted by async reset.
        rst = 1'b1;
        #1;
        chk("halt rst halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ins_ready = 1'b1;
        start_run();
        for (int k = 0; k < 3; k++) step();
        chk("pre-rst pc", 32'(ins_pc), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async rst valid", 32'(ins_valid), 32'd0);
        chk("async rst pc", 32'(ins_pc), 32'd0);
        chk("async rst count", 32'(instr_count), 32'd0);
        chk("async rst addr", 32'(mem_addr), 32'd0);
        chk("async rst data", 32'(ins_data), 32'd0);
        #2;
        rst = 1'b0;
        start_run();

        // Run to pc23, then branch back to 18.
        for (int k = 0; k < 23; k++) step();
        chk_issue("pre-redirect", 16'd23, 16'd23);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 16'd18;
        step();
        chk("redirect bubble valid", 32'(ins_valid), 32'd0);
        chk("redirect bubble count", 32'(instr_count), 32'd24);
        @(negedge clk);
        redirect = 1'b0;
        step();
        chk_issue("redirect target", 16'd18, 16'd24);
        chk("redirect target addr", 32'(mem_addr), 32'd19);
        step();
        step();
        chk_issue("post-redirect", 16'd20, 16'd26);

        // Redirect past the end of the program.
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 16'd30;
        step();
        chk("oor bubble valid", 32'(ins_valid), 32'd0);
        chk("oor count", 32'(instr_count), 32'd27);
        @(negedge clk);
        redirect = 1'b0;
        step();
        chk("oor halted", 32'(halted), 32'd1);
        chk("oor valid", 32'(ins_valid), 32'd0);
        step();
        chk("oor stays halted", 32'(halted), 32'd1);
        chk("oor count final", 32'(instr_count), 32'd27);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
